// File: rtl/led_stream_rx.sv
// led_stream_rx: oversampling receiver for the two-wire LED strip stream (start, LED and end frames).
// Define LED_RX_STATS_EN to add saturating frame_count/error_count outputs.
module led_stream_rx #(
    parameter int unsigned NUM_LEDS       = 72,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic        clk_stream,
    input  logic        data_stream,
    output logic [23:0] rgb,
    output logic [6:0]  led_index,
    output logic        rgb_valid,
    output logic        frame_done,
    output logic        frame_error,
`ifdef LED_RX_STATS_EN
    output logic [15:0] frame_count,
    output logic [15:0] error_count,
`endif
    output logic        busy
);
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StHunt, StLed, StEnd} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic [31:0]            sr_q, sr_d;
    logic [5:0]             zero_cnt_q, zero_cnt_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             led_cnt_q, led_cnt_d;
    logic [IdleW-1:0]       idle_cnt_q, idle_cnt_d;
    logic [23:0]            rgb_q, rgb_d;
    logic [6:0]             led_index_q, led_index_d;
    logic                   valid_q, valid_d, done_q, done_d, error_q, error_d;
    logic                   rise, bit_in;

    assign rise   = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign bit_in = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        zero_cnt_d  = zero_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        led_cnt_d   = led_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        rgb_d       = rgb_q;
        led_index_d = led_index_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        if (rise) begin
            sr_d = {sr_q[30:0], bit_in};
        end
        unique case (state_q)
            StHunt: begin
                idle_cnt_d = '0;
                if (rise) begin
                    if (bit_in) begin
                        zero_cnt_d = '0;
                    end else if (zero_cnt_q == 6'd31) begin
                        zero_cnt_d = '0;
                        bit_cnt_d  = '0;
                        led_cnt_d  = '0;
                        state_d    = StLed;
                    end else begin
                        zero_cnt_d = zero_cnt_q + 6'd1;
                    end
                end
            end
            StLed, StEnd: begin
                zero_cnt_d = '0;
                if (rise) begin
                    idle_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        // An all-ones word before NUM_LEDS is a white LED, so only the header matters.
                        if (state_q == StLed && sr_d[7:0] == 8'hFF) begin
                            rgb_d       = sr_d[31:8];
                            led_index_d = led_cnt_q;
                            valid_d     = 1'b1;
                            led_cnt_d   = led_cnt_q + 7'd1;
                            if (led_cnt_q == 7'(NUM_LEDS - 1)) begin
                                state_d = StEnd;
                            end
                        end else if (state_q == StEnd && sr_d == 32'hFFFF_FFFF) begin
                            done_d  = 1'b1;
                            state_d = StHunt;
                        end else begin
                            error_d = 1'b1;
                            state_d = StHunt;
                        end
                    end
                end else if (idle_cnt_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt_d = '0;
                    error_d    = 1'b1;
                    state_d    = StHunt;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            state_q     <= StHunt;
            sr_q        <= '0;
            zero_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            led_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            rgb_q       <= '0;
            led_index_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], clk_stream};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_stream};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            state_q     <= state_d;
            sr_q        <= sr_d;
            zero_cnt_q  <= zero_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            led_cnt_q   <= led_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            rgb_q       <= rgb_d;
            led_index_q <= led_index_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

`ifdef LED_RX_STATS_EN
    logic [15:0] frame_count_q, error_count_q;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            if (done_d && frame_count_q != 16'hFFFF) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (error_d && error_count_q != 16'hFFFF) begin
                error_count_q <= error_count_q + 16'd1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign error_count = error_count_q;
`endif

    assign rgb         = rgb_q;
    assign led_index   = led_index_q;
    assign rgb_valid   = valid_q;
    assign frame_done  = done_q;
    assign frame_error = error_q;
    assign busy        = (state_q != StHunt);

endmodule

// File: tb/tb_led_stream_rx.sv
// Self-checking bench for led_stream_rx: random-timed streams against a frame-level reference model.
module tb_led_stream_rx;
    localparam int NUM_LEDS = 72;
    localparam int TIMEOUT  = 1000;
    localparam int SYNC     = 2;

    logic        clk_100mhz = 1'b0;
    logic        rst = 1'b1;
    logic        clk_stream = 1'b0;
    logic        data_stream = 1'b0;
    logic [23:0] rgb;
    logic [6:0]  led_index;
    logic        rgb_valid, frame_done, frame_error, busy;
`ifdef LED_RX_STATS_EN
    logic [15:0] frame_count, error_count;
`endif

    always #5 clk_100mhz = ~clk_100mhz;

    led_stream_rx #(
        .NUM_LEDS      (NUM_LEDS),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .clk_stream (clk_stream),
        .data_stream(data_stream),
        .rgb        (rgb),
        .led_index  (led_index),
        .rgb_valid  (rgb_valid),
        .frame_done (frame_done),
        .frame_error(frame_error),
`ifdef LED_RX_STATS_EN
        .frame_count(frame_count),
        .error_count(error_count),
`endif
        .busy       (busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    // Reference model: expected outputs after each clock edge.
    logic [23:0] m_rgb;
    logic [6:0]  m_idx;
    logic        m_valid, m_done, m_error, m_busy;

    initial begin
        bit        clk_hist[$];
        bit        dat_hist[$];
        int        mode;  // 0 hunting, 1 LED frames, 2 end frame
        int        zeros, nbits, leds, idle;
        bit [31:0] word;
        bit        r, b;
        forever begin
            @(posedge clk_100mhz);
            if (rst) begin
                clk_hist = {};
                dat_hist = {};
                for (int i = 0; i < SYNC + 2; i++) begin
                    clk_hist.push_back(1'b0);
                    dat_hist.push_back(1'b0);
                end
                mode = 0; zeros = 0; nbits = 0; leds = 0; idle = 0; word = '0;
                m_rgb = '0; m_idx = '0; m_valid = 0; m_done = 0; m_error = 0; m_busy = 0;
                continue;
            end
            clk_hist.push_front(clk_stream);
            dat_hist.push_front(data_stream);
            void'(clk_hist.pop_back());
            void'(dat_hist.pop_back());
            // The wires reach the decoder SYNC edges late.
            r = clk_hist[SYNC] && !clk_hist[SYNC+1];
            b = dat_hist[SYNC];
            m_valid = 0; m_done = 0; m_error = 0;
            if (mode == 0) begin
                if (r) begin
                    if (b) zeros = 0;
                    else begin
                        zeros++;
                        if (zeros == 32) begin
                            mode = 1; zeros = 0; nbits = 0; leds = 0; idle = 0;
                        end
                    end
                end
            end else if (r) begin
                idle = 0;
                word = {word[30:0], b};
                nbits++;
                if (nbits == 32) begin
                    nbits = 0;
                    if (mode == 1) begin
                        if (word[7:0] == 8'hFF) begin
                            m_rgb = word[31:8];
                            m_idx = 7'(leds);
                            m_valid = 1;
                            leds++;
                            if (leds == NUM_LEDS) mode = 2;
                        end else begin
                            m_error = 1; mode = 0;
                        end
                    end else begin
                        if (word == 32'hFFFF_FFFF) m_done = 1;
                        else m_error = 1;
                        mode = 0;
                    end
                end
            end else begin
                idle++;
                if (idle == TIMEOUT) begin
                    m_error = 1; mode = 0;
                end
            end
            m_busy = (mode != 0);
        end
    end

    // Observations for the per-test literal checks.
    logic [23:0] obs_rgb[$];
    logic [6:0]  obs_idx[$];
    int          n_done, n_err, err_cyc, last_rise_cyc;

    task automatic clear_obs();
        obs_rgb = {}; obs_idx = {}; n_done = 0; n_err = 0; err_cyc = -1;
    endtask

    initial begin
        logic [34:0] exp_v, got_v;
        forever begin
            @(negedge clk_100mhz);
            exp_v = rst ? 35'd0 : {m_rgb, m_idx, m_valid, m_done, m_error, m_busy};
            got_v = {rgb, led_index, rgb_valid, frame_done, frame_error, busy};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got rgb=%h idx=%0d valid=%b done=%b err=%b busy=%b, required rgb=%h idx=%0d valid=%b done=%b err=%b busy=%b",
                         cyc, rgb, led_index, rgb_valid, frame_done, frame_error, busy,
                         exp_v[34:11], exp_v[10:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
            if (rgb_valid === 1'b1) begin
                obs_rgb.push_back(rgb);
                obs_idx.push_back(led_index);
            end
            if (frame_done === 1'b1) n_done++;
            if (frame_error === 1'b1) begin
                n_err++;
                err_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    task automatic send_bit(input bit b);
        data_stream = b;
        wait_cycles($urandom_range(3, 4));
        clk_stream = 1'b1;
        last_rise_cyc = cyc;
        wait_cycles($urandom_range(3, 4));
        clk_stream = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_start();
        for (int i = 0; i < 32; i++) send_bit(1'b0);
    endtask

    task automatic send_led(input logic [23:0] c);
        send_word({c, 8'hFF});
    endtask

    logic [23:0] colours[NUM_LEDS];

    initial begin
        logic [7:0]  v;
        logic [31:0] w;
        int          bad;

        wait_cycles(5);
        check("reset_rgb", {8'h0, rgb}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        wait_cycles(5);

        // 1: single LED after a start frame
        clear_obs();
        send_start();
        send_led(24'h123456);
        wait_cycles(10);
        check("t1_valid_count", obs_rgb.size(), 1);
        if (obs_rgb.size() > 0) begin
            check("t1_rgb", {8'h0, obs_rgb[0]}, 32'h0012_3456);
            check("t1_index", {25'h0, obs_idx[0]}, 0);
        end
        wait_cycles(TIMEOUT + 100);

        // 2: full frame {i,~i,i} then end frame
        clear_obs();
        wait_cycles($urandom_range(5, 50));
        send_start();
        for (int i = 0; i < NUM_LEDS; i++) begin
            v = i[7:0];
            send_led({v, ~v, v});
        end
        send_word(32'hFFFF_FFFF);
        wait_cycles(10);
        check("t2_valid_count", obs_rgb.size(), NUM_LEDS);
        bad = 0;
        foreach (obs_rgb[i]) begin
            v = i[7:0];
            if (obs_idx[i] !== 7'(i) || obs_rgb[i] !== {v, ~v, v}) bad++;
        end
        check("t2_order_bad", bad, 0);
        check("t2_done", n_done, 1);
        check("t2_errors", n_err, 0);
        check("t2_busy_after", {31'h0, busy}, 0);

        // 3: bad header on LED 5, trailing frames ignored, fresh start decodes from 0
        clear_obs();
        send_start();
        for (int i = 0; i < 10; i++) begin
            v = i[7:0];
            if (i == 5) send_word({v, ~v, v, 8'hFE});
            else send_led({v, ~v, v});
        end
        check("t3_valid_count", obs_rgb.size(), 5);
        check("t3_error", n_err, 1);
        send_start();
        send_led(24'hAABBCC);
        wait_cycles(10);
        check("t3_restart_count", obs_rgb.size(), 6);
        if (obs_rgb.size() == 6) begin
            check("t3_restart_idx", {25'h0, obs_idx[5]}, 0);
            check("t3_restart_rgb", {8'h0, obs_rgb[5]}, 32'h00AA_BBCC);
        end
        wait_cycles(TIMEOUT + 100);

        // 4: stall in LED 3 after 17 bits
        clear_obs();
        send_start();
        for (int i = 0; i < 3; i++) send_led(24'($urandom));
        w = $urandom;
        for (int i = 31; i >= 15; i--) send_bit(w[i]);
        wait_cycles(TIMEOUT + 100);
        check("t4_valid_count", obs_rgb.size(), 3);
        check("t4_error", n_err, 1);
        check("t4_latency", err_cyc - last_rise_cyc, SYNC + TIMEOUT + 1);
        check("t4_busy", {31'h0, busy}, 0);

        // 5: end frame after 10 LEDs is just a white LED, then timeout
        clear_obs();
        send_start();
        for (int i = 0; i < 10; i++) send_led(24'($urandom));
        send_word(32'hFFFF_FFFF);
        wait_cycles(TIMEOUT + 100);
        check("t5_valid_count", obs_rgb.size(), 11);
        if (obs_rgb.size() == 11) begin
            check("t5_white_idx", {25'h0, obs_idx[10]}, 10);
            check("t5_white_rgb", {8'h0, obs_rgb[10]}, 32'h00FF_FFFF);
        end
        check("t5_done", n_done, 0);
        check("t5_error", n_err, 1);

        // 6: reset mid-frame, then a full random frame and a back-to-back start
        send_start();
        for (int i = 0; i < 40; i++) send_led(24'($urandom));
        for (int i = 0; i < 9; i++) send_bit(1'($urandom));
        rst = 1'b1;
        wait_cycles(1);
        check("t6_rst_rgb", {8'h0, rgb}, 0);
        check("t6_rst_idx", {25'h0, led_index}, 0);
        check("t6_rst_busy", {31'h0, busy}, 0);
        wait_cycles(4);
        rst = 1'b0;
        wait_cycles(5);
        clear_obs();
        send_start();
        for (int i = 0; i < NUM_LEDS; i++) begin
            colours[i] = 24'($urandom);
            send_led(colours[i]);
        end
        send_word(32'hFFFF_FFFF);
        send_start();
        send_led(24'h010203);
        wait_cycles(10);
        check("t6_valid_count", obs_rgb.size(), NUM_LEDS + 1);
        bad = 0;
        for (int i = 0; i < NUM_LEDS && i < obs_rgb.size(); i++)
            if (obs_idx[i] !== 7'(i) || obs_rgb[i] !== colours[i]) bad++;
        check("t6_colour_bad", bad, 0);
        check("t6_done", n_done, 1);
        check("t6_errors", n_err, 0);
        if (obs_rgb.size() == NUM_LEDS + 1) begin
            check("t6_nogap_idx", {25'h0, obs_idx[NUM_LEDS]}, 0);
            check("t6_nogap_rgb", {8'h0, obs_rgb[NUM_LEDS]}, 32'h0001_0203);
        end
`ifdef LED_RX_STATS_EN
        check("t6_frame_count", {16'h0, frame_count}, 1);
        check("t6_error_count", {16'h0, error_count}, 0);
`endif
        wait_cycles(TIMEOUT + 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
